float_divider: RTL
==================

// Module: float_divider
// PURPOSE
//  Sequential IEEE-754 single-precision divider: z = a / b.
//  Companion to the FP multiplier in the float arithmetic set; same number handling
//  (denormal in/out, round-to-nearest-even, canonical NaN 0xFFC00000).
//  Start/done handshake with a radix-2 restoring mantissa divide (1 quotient bit/cycle).
// PARAMETERS
//  (none) - format fixed at binary32: 1 sign, 8 exponent (bias 127), 23 fraction.
// PORTS
//  clk    input   1   rising-edge clock
//  rst    input   1   asynchronous reset, active-high
//  start  input   1   request; sampled only in IDLE
//  a      input   32  dividend, captured on the accepting edge
//  b      input   32  divisor, captured on the accepting edge
//  busy   output  1   high from the cycle after acceptance until done
//  done   output  1   one-cycle pulse; z valid from this cycle on
//  z      output  32  quotient; held until the next done
//  dbz    output  1   divide-by-zero flag (finite nonzero / 0); updated with done
// BEHAVIOUR
//  Reset (any time, incl. mid-operation): state=IDLE, z=0, done=0, busy=0, dbz=0.
//  FSM: IDLE > UNPACK > SPECIAL > NORM > DIVIDE > ROUND > PACK > DONE > IDLE.
//  IDLE: start=1 latches a,b and moves to UNPACK. start while busy/DONE: ignored.
//  UNPACK (1 cyc): split fields; true exponent = field-127.
//   Denormal: exponent -126, no hidden 1.
//  SPECIAL (1 cyc): if special, load z/dbz and go to DONE:
//   NaN operand, 0/0, inf/inf  -> 0xFFC00000
//   inf/finite, finite!=0 / 0  -> {sa^sb, 0xFF, 0}; dbz=1 only for finite/0
//   0/nonzero, finite/inf      -> {sa^sb, 31'b0}
//  NORM (>=1 cyc): each cycle, shift left (exponent -1) any mantissa with bit23=0.
//   Leave when both bit23=1. Cost: 1 + max leading-zero count of the operands.
//  DIVIDE (27 cyc): restoring divide of ma<<26 by mb -> 27-bit q, remainder r.
//   ze = ea - eb, 10-bit signed.
//  ROUND (1 cyc):
//   - if q[26]=0: shift q left 1, ze -= 1
//   - mant = q[26:3], guard = q[2], round = q[1], sticky = q[0] | (r != 0)
//   - if ze < -126: shift right by (-126-ze) (cap 26), ORing lost bits into sticky; ze = -126
//   - RNE increment when guard & (round | sticky | mant[0])
//   - mantissa carry-out (0xFFFFFF+1) gives 0x800000 and ze += 1
//  PACK (1 cyc): ze > 127 -> {s, 0xFF, 0} (inf). ze = -126 and mant[23]=0 -> exp field 0.
//   Otherwise exp field = ze + 127. fraction = mant[22:0].
//  DONE: done=1 for exactly one cycle, busy=0, then IDLE.
//   A start in the DONE cycle is ignored.
//  Latency (acceptance edge = cycle 0), done high in:
//   special case                  cycle 3
//   normal operands               cycle 33
//   denormal operands             cycle 33 + k, k = max leading zeros (<= 23)
// TESTING
//  1. a=0x40C00000 (6.0), b=0x40000000 -> z=0x40400000, dbz=0, done exactly at cycle 33.
//  2. a=0x3F800000, b=0x40400000 (1/3) -> z=0x3EAAAAAB (RNE rounds up).
//  3. a=0x3F800000, b=0 -> z=0x7F800000, dbz=1, done at cycle 3.
//     a=0, b=0 -> z=0xFFC00000, dbz=0.
//  4. a=0x7F7FFFFF, b=0x3F000000 -> z=0x7F800000 (overflow).
//     a=0xBF800000, b=0x40800000 -> z=0xBE800000.
//  5. a=0x00000001, b=0x40000000 -> z=0x00000000 (tie to even); done at cycle 33+23.
//     a=0x00800000, b=0x40000000 -> z=0x00400000.
//  6. Assert rst in DIVIDE -> z=0, busy=0, done=0 immediately.
//     start pulsed while busy -> no effect on the running result.

Source files
------------

// File: rtl/float_divider_if.sv
// rtl/float_divider_if.sv - start/done handshake bundle for the binary32 divider
interface float_divider_if;
   logic        start;
   logic [31:0] a;
   logic [31:0] b;
   logic        busy;
   logic        done;
   logic [31:0] z;
   logic        dbz;

   modport master (output start, a, b, input busy, done, z, dbz);
   modport slave  (input start, a, b, output busy, done, z, dbz);
endinterface

// File: rtl/float_divider.sv
// rtl/float_divider.sv - sequential binary32 divider, restoring mantissa divide, RNE
module float_divider (
   input  logic           clk,
   input  logic           rst,
   float_divider_if.slave io
);
   typedef enum logic [2:0] {
      S_IDLE, S_UNPACK, S_SPECIAL, S_NORM, S_DIVIDE, S_ROUND, S_PACK, S_DONE
   } state_t;

   state_t             state_q, state_d;
   logic [31:0]        a_q, a_d, b_q, b_d, z_q, z_d;
   logic               s_q, s_d, dbz_q, dbz_d;
   logic signed [9:0]  ea_q, ea_d, eb_q, eb_d, ze_q, ze_d;
   logic [23:0]        ma_q, ma_d, mb_q, mb_d, mant_q, mant_d;
   logic [26:0]        q_q, q_d;
   logic [25:0]        rem_q, rem_d;
   logic [4:0]         cnt_q, cnt_d;

   logic               nan_a, nan_b, inf_a, inf_b, zero_a, zero_b, ge;
   logic [26:0]        q1;
   logic signed [9:0]  ze1, shamt;
   logic [25:0]        v, mask;
   logic [4:0]         sh;
   logic               g, rb, st;
   logic [23:0]        mant;
   logic [24:0]        sum;

   assign nan_a  = (a_q[30:23] == 8'hFF) && (a_q[22:0] != 23'd0);
   assign nan_b  = (b_q[30:23] == 8'hFF) && (b_q[22:0] != 23'd0);
   assign inf_a  = (a_q[30:23] == 8'hFF) && (a_q[22:0] == 23'd0);
   assign inf_b  = (b_q[30:23] == 8'hFF) && (b_q[22:0] == 23'd0);
   assign zero_a = (a_q[30:0] == 31'd0);
   assign zero_b = (b_q[30:0] == 31'd0);

   assign io.z    = z_q;
   assign io.dbz  = dbz_q;
   assign io.done = (state_q == S_DONE);
   assign io.busy = (state_q != S_IDLE) && (state_q != S_DONE);

   always_comb begin
      state_d = state_q;
      a_d = a_q; b_d = b_q; z_d = z_q; s_d = s_q; dbz_d = dbz_q;
      ea_d = ea_q; eb_d = eb_q; ze_d = ze_q;
      ma_d = ma_q; mb_d = mb_q; mant_d = mant_q;
      q_d = q_q; rem_d = rem_q; cnt_d = cnt_q;
      q1 = '0; ze1 = '0; shamt = '0; v = '0; mask = '0; sh = '0;
      g = 1'b0; rb = 1'b0; st = 1'b0; mant = '0; sum = '0;
      ge = (rem_q >= {2'b00, mb_q});
      case (state_q)
         S_IDLE: if (io.start) begin
            a_d = io.a;
            b_d = io.b;
            state_d = S_UNPACK;
         end
         S_UNPACK: begin
            s_d  = a_q[31] ^ b_q[31];
            ea_d = (a_q[30:23] == 8'd0) ? -10'sd126 : $signed({2'b00, a_q[30:23]}) - 10'sd127;
            eb_d = (b_q[30:23] == 8'd0) ? -10'sd126 : $signed({2'b00, b_q[30:23]}) - 10'sd127;
            ma_d = {a_q[30:23] != 8'd0, a_q[22:0]};
            mb_d = {b_q[30:23] != 8'd0, b_q[22:0]};
            state_d = S_SPECIAL;
         end
         S_SPECIAL: begin
            state_d = S_DONE;
            dbz_d   = 1'b0;
            if (nan_a || nan_b || (zero_a && zero_b) || (inf_a && inf_b))
               z_d = 32'hFFC0_0000;
            else if (inf_a)
               z_d = {s_q, 8'hFF, 23'd0};
            else if (zero_b) begin
               z_d   = {s_q, 8'hFF, 23'd0};
               dbz_d = 1'b1;
            end else if (zero_a || inf_b)
               z_d = {s_q, 31'd0};
            else
               state_d = S_NORM;
         end
         S_NORM: begin
            if (ma_q[23] && mb_q[23]) begin
               ze_d    = ea_q - eb_q;
               rem_d   = {2'b00, ma_q};
               q_d     = '0;
               cnt_d   = '0;
               state_d = S_DIVIDE;
            end else begin
               if (!ma_q[23]) begin ma_d = ma_q << 1; ea_d = ea_q - 10'sd1; end
               if (!mb_q[23]) begin mb_d = mb_q << 1; eb_d = eb_q - 10'sd1; end
            end
         end
         S_DIVIDE: begin
            q_d   = {q_q[25:0], ge};
            rem_d = ge ? (rem_q - {2'b00, mb_q}) << 1 : rem_q << 1;
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'd26) state_d = S_ROUND;
         end
         S_ROUND: begin
            if (q_q[26]) begin q1 = q_q; ze1 = ze_q; end
            else begin q1 = {q_q[25:0], 1'b0}; ze1 = ze_q - 10'sd1; end
            v  = q1[26:1];
            st = q1[0] | (rem_q != 26'd0);
            // Below the denormal floor: slide right, folding lost bits into sticky
            if (ze1 < -10'sd126) begin
               shamt = -10'sd126 - ze1;
               sh    = (shamt > 10'sd26) ? 5'd26 : shamt[4:0];
               mask  = (26'd1 << sh) - 26'd1;
               st    = st | ((v & mask) != 26'd0);
               v     = v >> sh;
               ze1   = -10'sd126;
            end
            mant = v[25:2];
            g    = v[1];
            rb   = v[0];
            sum  = {1'b0, mant} + {24'd0, g & (rb | st | mant[0])};
            if (sum[24]) begin
               mant_d = 24'h80_0000;
               ze_d   = ze1 + 10'sd1;
            end else begin
               mant_d = sum[23:0];
               ze_d   = ze1;
            end
            state_d = S_PACK;
         end
         S_PACK: begin
            dbz_d = 1'b0;
            if (ze_q > 10'sd127)
               z_d = {s_q, 8'hFF, 23'd0};
            else if ((ze_q == -10'sd126) && !mant_q[23])
               z_d = {s_q, 8'd0, mant_q[22:0]};
            else
               z_d = {s_q, ze_q[7:0] + 8'd127, mant_q[22:0]};
            state_d = S_DONE;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         a_q <= '0; b_q <= '0; z_q <= '0; s_q <= 1'b0; dbz_q <= 1'b0;
         ea_q <= '0; eb_q <= '0; ze_q <= '0;
         ma_q <= '0; mb_q <= '0; mant_q <= '0;
         q_q <= '0; rem_q <= '0; cnt_q <= '0;
      end else begin
         state_q <= state_d;
         a_q <= a_d; b_q <= b_d; z_q <= z_d; s_q <= s_d; dbz_q <= dbz_d;
         ea_q <= ea_d; eb_q <= eb_d; ze_q <= ze_d;
         ma_q <= ma_d; mb_q <= mb_d; mant_q <= mant_d;
         q_q <= q_d; rem_q <= rem_d; cnt_q <= cnt_d;
      end
   end
endmodule
